// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg: shared widths, branch encodings and the EX/MEM payload layout.
package ex_mem_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned REG_W     = 5;
    localparam int unsigned PAYLOAD_W = 2 * DATA_W + REG_W + 4;

    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_BEQ  = 3'b001;
    localparam logic [2:0] BR_BNE  = 3'b010;
    localparam logic [2:0] BR_BGEZ = 3'b011;
    localparam logic [2:0] BR_BLTZ = 3'b100;
    localparam logic [2:0] BR_BGTZ = 3'b101;
    localparam logic [2:0] BR_BLEZ = 3'b110;
    localparam logic [2:0] BR_J    = 3'b111;

    // Instruction payload carried from EX into MEM.
    typedef struct packed {
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] store_data;
        logic [REG_W-1:0]  dest_reg;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
    } payload_t;

endpackage

// File: rtl/ex_mem_skid.sv
// ex_mem_skid: generic 2-entry valid/ready skid buffer; every output is a flop.
module ex_mem_skid #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         p_valid;
    logic [W-1:0] p_data;
    logic         s_valid;
    logic [W-1:0] s_data;
    logic         accept_c;
    logic         emit_c;

    assign accept_c  = in_valid & in_ready;
    assign emit_c    = p_valid & out_ready;
    assign out_valid = p_valid;
    assign out_data  = p_data;

    // Primary/skid entries; in_ready tracks !s_valid as its own flop so it never depends on out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_valid  <= 1'b0;
            p_data   <= '0;
            s_valid  <= 1'b0;
            s_data   <= '0;
            in_ready <= 1'b1;
        end else begin
            if (accept_c && (!p_valid || emit_c)) begin
                // in_ready implies S is empty, so the new word goes straight to P.
                p_valid <= 1'b1;
                p_data  <= in_data;
            end else if (accept_c) begin
                s_valid  <= 1'b1;
                s_data   <= in_data;
                in_ready <= 1'b0;
            end else if (emit_c && s_valid) begin
                p_data   <= s_data;
                s_valid  <= 1'b0;
                in_ready <= 1'b1;
            end else if (emit_c) begin
                p_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: branch resolution, redirect pulse and EX->MEM skid buffering.
module ex_mem_stage
    import ex_mem_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              InValid,
    output logic              InReady,
    input  logic [DATA_W-1:0] ALUResult,
    input  logic              Zero,
    input  logic [DATA_W-1:0] StoreData,
    input  logic [REG_W-1:0]  DestReg,
    input  logic              RegWrite,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              MemToReg,
    input  logic [2:0]        BranchType,
    input  logic [DATA_W-1:0] BranchTarget,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [DATA_W-1:0] OutALUResult,
    output logic [DATA_W-1:0] OutStoreData,
    output logic [REG_W-1:0]  OutDestReg,
    output logic              OutRegWrite,
    output logic              OutMemRead,
    output logic              OutMemWrite,
    output logic              OutMemToReg,
    output logic              Redirect,
    output logic [DATA_W-1:0] RedirectPC,
    output logic [31:0]       TakenCount
);

    payload_t in_pl;
    payload_t out_pl;
    logic     accept_c;
    logic     cond_c;
    logic     taken_c;
    logic     sign_c;

    assign accept_c = InValid & InReady;
    assign sign_c   = ALUResult[DATA_W-1];
    assign taken_c  = accept_c & cond_c & ~Redirect;

    // Branch condition decode from the ALU sign bit and zero flag.
    always_comb begin
        cond_c = 1'b0;
        case (BranchType)
            BR_NONE: cond_c = 1'b0;
            BR_BEQ:  cond_c = Zero;
            BR_BNE:  cond_c = ~Zero;
            BR_BGEZ: cond_c = ~sign_c;
            BR_BLTZ: cond_c = sign_c;
            BR_BGTZ: cond_c = ~sign_c & ~Zero;
            BR_BLEZ: cond_c = sign_c | Zero;
            BR_J:    cond_c = 1'b1;
            default: cond_c = 1'b0;
        endcase
    end

    // Pack the EX-side fields into the buffered payload.
    always_comb begin
        in_pl            = '0;
        in_pl.alu_result = ALUResult;
        in_pl.store_data = StoreData;
        in_pl.dest_reg   = DestReg;
        in_pl.reg_write  = RegWrite;
        in_pl.mem_read   = MemRead;
        in_pl.mem_write  = MemWrite;
        in_pl.mem_to_reg = MemToReg;
    end

    // The wrong-path instruction is handshaken (InReady honoured) but never enters the buffer.
    ex_mem_skid #(
        .W (PAYLOAD_W)
    ) u_skid (
        .clk       (Clk),
        .rst       (Reset),
        .in_valid  (InValid & ~Redirect),
        .in_ready  (InReady),
        .in_data   (in_pl),
        .out_valid (OutValid),
        .out_ready (OutReady),
        .out_data  (out_pl)
    );

    assign OutALUResult = out_pl.alu_result;
    assign OutStoreData = out_pl.store_data;
    assign OutDestReg   = out_pl.dest_reg;
    assign OutRegWrite  = out_pl.reg_write;
    assign OutMemRead   = out_pl.mem_read;
    assign OutMemWrite  = out_pl.mem_write;
    assign OutMemToReg  = out_pl.mem_to_reg;

    // One-cycle redirect pulse with its target, plus the wrapping taken counter.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Redirect   <= 1'b0;
            RedirectPC <= '0;
            TakenCount <= '0;
        end else begin
            Redirect <= taken_c;
            if (taken_c) begin
                RedirectPC <= BranchTarget;
                TakenCount <= TakenCount + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: scoreboard bench for the EX/MEM stage.
module tb_ex_mem_stage;
    import ex_mem_pkg::*;

    logic              Clk = 1'b0;
    logic              Reset;
    logic              InValid;
    logic              InReady;
    logic [DATA_W-1:0] ALUResult;
    logic              Zero;
    logic [DATA_W-1:0] StoreData;
    logic [REG_W-1:0]  DestReg;
    logic              RegWrite, MemRead, MemWrite, MemToReg;
    logic [2:0]        BranchType;
    logic [DATA_W-1:0] BranchTarget;
    logic              OutValid;
    logic              OutReady;
    logic [DATA_W-1:0] OutALUResult;
    logic [DATA_W-1:0] OutStoreData;
    logic [REG_W-1:0]  OutDestReg;
    logic              OutRegWrite, OutMemRead, OutMemWrite, OutMemToReg;
    logic              Redirect;
    logic [DATA_W-1:0] RedirectPC;
    logic [31:0]       TakenCount;

    ex_mem_stage dut (
        .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady),
        .ALUResult(ALUResult), .Zero(Zero), .StoreData(StoreData), .DestReg(DestReg),
        .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg),
        .BranchType(BranchType), .BranchTarget(BranchTarget),
        .OutValid(OutValid), .OutReady(OutReady),
        .OutALUResult(OutALUResult), .OutStoreData(OutStoreData), .OutDestReg(OutDestReg),
        .OutRegWrite(OutRegWrite), .OutMemRead(OutMemRead), .OutMemWrite(OutMemWrite),
        .OutMemToReg(OutMemToReg), .Redirect(Redirect), .RedirectPC(RedirectPC),
        .TakenCount(TakenCount)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] sd;
        logic [4:0]  dr;
        logic [3:0]  ctl;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        m_redirect = 1'b0;
    logic [31:0] m_rpc = '0;
    logic [31:0] m_taken = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic br_cond(input logic [2:0] bt, input logic [31:0] a, input logic z);
        logic neg;
        neg = a[31];
        case (bt)
            3'd1:    return z;
            3'd2:    return !z;
            3'd3:    return !neg;
            3'd4:    return neg;
            3'd5:    return !neg && !z;
            3'd6:    return neg || z;
            3'd7:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Drive one instruction; side fields are derived from the ALU value.
    task automatic drive(input logic v, input logic [31:0] alu, input logic z,
                         input logic [2:0] bt, input logic [31:0] tgt, input logic rdy);
        InValid      = v;
        ALUResult    = alu;
        Zero         = z;
        StoreData    = alu ^ 32'h5555_5555;
        DestReg      = alu[4:0] ^ 5'h1B;
        {RegWrite, MemRead, MemWrite, MemToReg} = alu[7:4];
        BranchType   = bt;
        BranchTarget = tgt;
        OutReady     = rdy;
    endtask

    // One clock: check outputs at negedge against the model, then advance the model.
    task automatic cyc();
        logic acc, emit, nr;
        exp_t e;
        @(negedge Clk);
        check_eq("in_ready", 32'(InReady), 32'(sb.size() < 2));
        check_eq("out_valid", 32'(OutValid), 32'(sb.size() != 0));
        check_eq("squash", 32'(OutValid && OutALUResult == 32'hDEAD), 32'd0);
        if (OutValid && sb.size() != 0) begin
            check_eq("alu", OutALUResult, sb[0].alu);
            check_eq("store", OutStoreData, sb[0].sd);
            check_eq("dest", 32'(OutDestReg), 32'(sb[0].dr));
            check_eq("ctl", 32'({OutRegWrite, OutMemRead, OutMemWrite, OutMemToReg}), 32'(sb[0].ctl));
        end
        check_eq("redirect", 32'(Redirect), 32'(m_redirect));
        if (m_redirect) check_eq("redirect_pc", RedirectPC, m_rpc);
        check_eq("taken_count", TakenCount, m_taken);
        acc  = InValid && (sb.size() < 2);
        emit = (sb.size() != 0) && OutReady;
        if (emit) void'(sb.pop_front());
        if (acc && !m_redirect) begin
            e.alu = ALUResult; e.sd = StoreData; e.dr = DestReg;
            e.ctl = {RegWrite, MemRead, MemWrite, MemToReg};
            sb.push_back(e);
        end
        nr = acc && br_cond(BranchType, ALUResult, Zero) && !m_redirect;
        if (nr) begin
            m_rpc   = BranchTarget;
            m_taken = m_taken + 32'd1;
        end
        m_redirect = nr;
        @(posedge Clk);
        #1;
    endtask

    task automatic idle(input int n, input logic rdy);
        drive(1'b0, 32'h0, 1'b0, BR_NONE, 32'h0, rdy);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        logic [31:0] r;
        Reset = 1'b1;
        drive(1'b0, 32'h0, 1'b0, BR_NONE, 32'h0, 1'b1);
        @(posedge Clk);
        #1;
        check_eq("rst_out_valid", 32'(OutValid), 32'd0);
        check_eq("rst_in_ready", 32'(InReady), 32'd1);
        check_eq("rst_redirect", 32'(Redirect), 32'd0);
        check_eq("rst_redirect_pc", RedirectPC, 32'd0);
        check_eq("rst_taken", TakenCount, 32'd0);
        check_eq("rst_alu", OutALUResult, 32'd0);
        check_eq("rst_store", OutStoreData, 32'd0);
        Reset = 1'b0;

        // Streaming with OutReady held high.
        drive(1'b1, 32'h10, 1'b0, BR_NONE, 32'h0, 1'b1); cyc();
        drive(1'b1, 32'h20, 1'b0, BR_NONE, 32'h0, 1'b1); cyc();
        drive(1'b1, 32'h30, 1'b0, BR_NONE, 32'h0, 1'b1); cyc();
        idle(2, 1'b1);

        // Backpressure: fill P and S, hold, then drain.
        drive(1'b1, 32'hA, 1'b0, BR_NONE, 32'h0, 1'b0); cyc();
        drive(1'b1, 32'hB, 1'b0, BR_NONE, 32'h0, 1'b0); cyc();
        drive(1'b1, 32'hC, 1'b0, BR_NONE, 32'h0, 1'b0); cyc();
        idle(2, 1'b0);
        check_eq("bp_held", OutALUResult, 32'hA);
        idle(3, 1'b1);

        // beq taken, then a squashed wrong-path instruction, then beq not taken.
        drive(1'b1, 32'h0, 1'b1, BR_BEQ, 32'h0040_0040, 1'b1); cyc();
        check_eq("beq_pc", RedirectPC, 32'h0040_0040);
        drive(1'b1, 32'hDEAD, 1'b0, BR_J, 32'h0000_1234, 1'b1); cyc();
        idle(2, 1'b1);
        drive(1'b1, 32'h4, 1'b0, BR_BEQ, 32'h0040_0080, 1'b1); cyc();
        idle(2, 1'b1);

        // Signed conditions.
        drive(1'b1, 32'h8000_0000, 1'b0, BR_BLTZ, 32'h0000_0100, 1'b1); cyc();
        idle(1, 1'b1);
        drive(1'b1, 32'h0, 1'b1, BR_BGTZ, 32'h0000_0200, 1'b1); cyc();
        idle(1, 1'b1);
        drive(1'b1, 32'h0, 1'b1, BR_BLEZ, 32'h0000_0300, 1'b1); cyc();
        idle(1, 1'b1);
        drive(1'b1, 32'h7000_0000, 1'b0, BR_BGEZ, 32'h0000_0400, 1'b1); cyc();
        drive(1'b1, 32'h5, 1'b0, BR_BNE, 32'h0000_0500, 1'b1); cyc();
        idle(2, 1'b1);

        // Random mix of valid, backpressure and branch types.
        for (int i = 0; i < 300; i++) begin
            r = $urandom();
            drive(($urandom_range(0, 9) < 7), {r[31:16], 16'(i)}, r[2],
                  3'($urandom_range(0, 7)), $urandom(), ($urandom_range(0, 9) < 6));
            cyc();
        end
        idle(4, 1'b1);

        // Asynchronous reset while P and S are both full and a branch has been counted.
        drive(1'b1, 32'h0, 1'b0, BR_J, 32'h0000_0600, 1'b0); cyc();
        drive(1'b1, 32'h77, 1'b0, BR_NONE, 32'h0, 1'b0); cyc();
        drive(1'b1, 32'h88, 1'b0, BR_NONE, 32'h0, 1'b0); cyc();
        InValid = 1'b0;
        #2;
        Reset = 1'b1;
        #1;
        check_eq("amid_out_valid", 32'(OutValid), 32'd0);
        check_eq("amid_in_ready", 32'(InReady), 32'd1);
        check_eq("amid_taken", TakenCount, 32'd0);
        check_eq("amid_alu", OutALUResult, 32'd0);
        Reset = 1'b0;
        sb.delete();
        m_redirect = 1'b0;
        m_rpc = '0;
        m_taken = '0;
        idle(2, 1'b1);
        drive(1'b1, 32'h99, 1'b0, BR_NONE, 32'h0, 1'b1); cyc();
        idle(2, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
